// File: rtl/fetch_unit.sv
// Instruction fetch front end: walks a row-address pc through a shared storage read port
// and buffers returned rows with their addresses in a small in-order queue for decode.
module fetch_unit #(
    parameter int unsigned READ_ADDR_SIZE = 28,
    parameter int unsigned ROW_WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter logic [READ_ADDR_SIZE-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      startSig,
    output logic [READ_ADDR_SIZE-1:0] memReadAddr,
    output logic                      memReadEn,
    input  logic                      memReadFin,
    input  logic [ROW_WIDTH-1:0]      memReadData,
    input  logic                      redirectEn,
    input  logic [READ_ADDR_SIZE-1:0] redirectAddr,
    output logic                      instValid,
    output logic [ROW_WIDTH-1:0]      instData,
    output logic [READ_ADDR_SIZE-1:0] instAddr,
    input  logic                      instReady,
    output logic [31:0]               stallCnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StFull} state_e;

    state_e                    state_q, state_d;
    logic [READ_ADDR_SIZE-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [31:0]               stall_q, stall_d;

    logic [ROW_WIDTH-1:0]      data_mem [FIFO_DEPTH];
    logic [READ_ADDR_SIZE-1:0] addr_mem [FIFO_DEPTH];

    logic push, pop;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        stall_d  = stall_q;

        instValid = (count_q != '0);
        memReadEn = (state_q == StFetch) && (count_q < DEPTH_C) && !redirectEn;
        push      = memReadEn && memReadFin;
        pop       = instValid && instReady;

        unique case (state_q)
            StIdle: begin
                if (startSig) state_d = StFetch;
            end
            StFetch, StFull: begin
                if (redirectEn) begin
                    // Flush wins over any same-cycle pop; fetch restarts at the target.
                    count_d  = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    pc_d     = redirectAddr;
                    state_d  = StFetch;
                end else begin
                    if (push) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        pc_d     = pc_q + 1'b1;
                    end
                    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
                    if (memReadEn && !memReadFin) stall_d = stall_q + 32'd1;
                    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
                    state_d = (count_d == DEPTH_C) ? StFull : StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            stall_q  <= stall_d;
        end
    end

    // Queue storage needs no reset: the head is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            data_mem[wr_ptr_q] <= memReadData;
            addr_mem[wr_ptr_q] <= pc_q;
        end
    end

    assign memReadAddr = pc_q;
    assign instData    = instValid ? data_mem[rd_ptr_q] : '0;
    assign instAddr    = instValid ? addr_mem[rd_ptr_q] : '0;
    assign stallCnt    = stall_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: storage model returns row r as r + 0x100; every check
// compares against hand-derived constants.
module tb_fetch_unit;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_sig;
    logic [AW-1:0] mem_read_addr;
    logic          mem_read_en;
    logic          mem_read_fin;
    logic [DW-1:0] mem_read_data;
    logic          redirect_en;
    logic [AW-1:0] redirect_addr;
    logic          inst_valid;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_addr;
    logic          inst_ready;
    logic [31:0]   stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit #(
        .READ_ADDR_SIZE(AW),
        .ROW_WIDTH     (DW),
        .FIFO_DEPTH    (4),
        .RESET_PC      ('0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .startSig    (start_sig),
        .memReadAddr (mem_read_addr),
        .memReadEn   (mem_read_en),
        .memReadFin  (mem_read_fin),
        .memReadData (mem_read_data),
        .redirectEn  (redirect_en),
        .redirectAddr(redirect_addr),
        .instValid   (inst_valid),
        .instData    (inst_data),
        .instAddr    (inst_addr),
        .instReady   (inst_ready),
        .stallCnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    assign mem_read_data = 32'(mem_read_addr) + 32'h100;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks run 1 unit later still.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; start_sig = 1'b0; mem_read_fin = 1'b1; redirect_en = 1'b0;
        redirect_addr = '0; inst_ready = 1'b0;
        tick(); tick();
        settle();
        check("rst_en", 64'(mem_read_en), 0);
        check("rst_addr", 64'(mem_read_addr), 0);
        check("rst_valid", 64'(inst_valid), 0);
        check("rst_data", 64'(inst_data), 0);
        check("rst_iaddr", 64'(inst_addr), 0);
        check("rst_stall", 64'(stall_cnt), 0);

        // Idle: redirect and read grants are ignored.
        rst = 1'b0; redirect_en = 1'b1; redirect_addr = 28'h55;
        tick();
        redirect_en = 1'b0;
        settle();
        check("idle_redir_addr", 64'(mem_read_addr), 0);
        check("idle_en", 64'(mem_read_en), 0);
        check("idle_valid", 64'(inst_valid), 0);

        // Streaming: one instruction per cycle from cycle 2; start ignored while fetching.
        start_sig = 1'b1; inst_ready = 1'b1;
        tick();
        start_sig = 1'b0;
        settle();
        check("c1_en", 64'(mem_read_en), 1);
        check("c1_addr", 64'(mem_read_addr), 0);
        check("c1_valid", 64'(inst_valid), 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            start_sig = (i == 2);
            settle();
            check("str_valid", 64'(inst_valid), 1);
            check("str_iaddr", 64'(inst_addr), 64'(i));
            check("str_data", 64'(inst_data), 64'(32'h100 + i));
            check("str_pc", 64'(mem_read_addr), 64'(i + 1));
            tick();
        end
        start_sig = 1'b0;

        // Reset with a grant pending, then fill to FULL with decode stalled.
        rst = 1'b1; mem_read_fin = 1'b1; inst_ready = 1'b0;
        tick();
        rst = 1'b0;
        settle();
        check("rst2_valid", 64'(inst_valid), 0);
        check("rst2_addr", 64'(mem_read_addr), 0);
        start_sig = 1'b1;
        tick();
        start_sig = 1'b0;
        tick(); tick(); tick(); tick();
        settle();
        check("full_en", 64'(mem_read_en), 0);
        check("full_addr", 64'(mem_read_addr), 4);
        check("full_head", 64'(inst_addr), 0);
        tick();
        settle();
        check("full_hold_addr", 64'(mem_read_addr), 4);
        inst_ready = 1'b1;
        settle();
        check("full_pop_en", 64'(mem_read_en), 0);
        tick();
        inst_ready = 1'b0;
        settle();
        check("refetch_en", 64'(mem_read_en), 1);
        check("refetch_addr", 64'(mem_read_addr), 4);
        check("refetch_head", 64'(inst_addr), 1);
        tick();
        settle();
        check("refull_en", 64'(mem_read_en), 0);
        check("refull_addr", 64'(mem_read_addr), 5);

        // Drain while refilling: simultaneous push/pop must keep order.
        inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            check("order_iaddr", 64'(inst_addr), 64'(1 + k));
            check("order_data", 64'(inst_data), 64'(32'h101 + k));
            tick();
        end
        settle();
        check("order_pc", 64'(mem_read_addr), 10);

        // Redirect with entries queued and decode ready: queue flushed, pc retargeted.
        redirect_en = 1'b1; redirect_addr = 28'h40;
        settle();
        check("redir_en", 64'(mem_read_en), 0);
        tick();
        redirect_en = 1'b0; inst_ready = 1'b0; mem_read_fin = 1'b0;
        settle();
        check("redir_valid", 64'(inst_valid), 0);
        check("redir_data", 64'(inst_data), 0);
        check("redir_addr", 64'(mem_read_addr), 28'h40);
        check("redir_en2", 64'(mem_read_en), 1);

        // Three lost arbitration cycles.
        tick(); tick(); tick();
        settle();
        check("stall_cnt", 64'(stall_cnt), 3);
        check("stall_addr", 64'(mem_read_addr), 28'h40);
        check("stall_valid", 64'(inst_valid), 0);
        mem_read_fin = 1'b1;
        tick();
        settle();
        check("post_stall_iaddr", 64'(inst_addr), 28'h40);
        check("post_stall_data", 64'(inst_data), 32'h140);
        check("post_stall_cnt", 64'(stall_cnt), 3);

        // pc wrap at the top of the address space.
        redirect_en = 1'b1; redirect_addr = 28'hFFF_FFFF; inst_ready = 1'b1;
        tick();
        redirect_en = 1'b0;
        settle();
        check("wrap_pre", 64'(mem_read_addr), 28'hFFF_FFFF);
        tick();
        inst_ready = 1'b0;
        settle();
        check("wrap_addr", 64'(mem_read_addr), 0);
        check("wrap_iaddr", 64'(inst_addr), 28'hFFF_FFFF);
        check("wrap_data", 64'(inst_data), 32'h1000_00FF);
        tick();
        settle();
        check("two_queued_head", 64'(inst_addr), 28'hFFF_FFFF);
        check("two_queued_pc", 64'(mem_read_addr), 1);

        // Mid-fetch reset drops the queue and clears the stall counter.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rst3_valid", 64'(inst_valid), 0);
        check("rst3_addr", 64'(mem_read_addr), 0);
        check("rst3_stall", 64'(stall_cnt), 0);
        check("rst3_en", 64'(mem_read_en), 0);
        tick();
        settle();
        check("rst3_idle_valid", 64'(inst_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
